// File: rtl/tuner_ctrl_arb_mc.sv
// Shares one ring heater DAC and one power ADC between NUM_CH tuner engines.
// Each grant runs DAC write -> settle wait -> averaged power measurement -> response.
module tuner_ctrl_arb_mc #(
    parameter int DAC_WIDTH     = 8,
    parameter int ADC_WIDTH     = 8,
    parameter int NUM_CH        = 3,
    parameter int SETTLE_CYCLES = 4,
    parameter int AVG_LOG2      = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [ADC_WIDTH-1:0]          i_dig_ring_pwr,
    input  logic                          i_cfg_arb_rr,
    input  logic [NUM_CH-1:0]             i_cfg_ch_en,
    input  logic [NUM_CH-1:0]             i_req_val,
    input  logic [NUM_CH*DAC_WIDTH-1:0]   i_req_ring_tune,
    output logic [NUM_CH-1:0]             o_req_rdy,
    output logic [NUM_CH-1:0]             o_rsp_val,
    output logic [DAC_WIDTH-1:0]          o_rsp_ring_tune,
    output logic [ADC_WIDTH-1:0]          o_rsp_ring_pwr,
    output logic [DAC_WIDTH-1:0]          o_dig_afe_ring_tune,
    output logic                          o_afe_ring_tune_val,
    input  logic                          i_afe_ring_tune_rdy,
    output logic [$clog2(NUM_CH)-1:0]     o_grant_ch,
    output logic                          o_busy,
    output logic [2:0]                    o_state_mon
);
    localparam int GW      = $clog2(NUM_CH);
    localparam int ACC_W   = ADC_WIDTH + AVG_LOG2;
    localparam int NSAMP   = 2 ** AVG_LOG2;
    localparam int CNT_MAX = (SETTLE_CYCLES > NSAMP) ? SETTLE_CYCLES : NSAMP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(NSAMP - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    state_t             state_reg, state_next;
    logic [GW-1:0]      grant_reg, last_grant_reg;
    logic [DAC_WIDTH-1:0] tune_reg, rsp_tune_reg;
    logic [ADC_WIDTH-1:0] rsp_pwr_reg;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg;

    logic [NUM_CH-1:0]  elig;
    logic               any_elig;
    logic               found_hi;
    logic [GW-1:0]      winner_lo, winner_hi, winner;
    logic [DAC_WIDTH-1:0] win_code;

    assign elig     = i_req_val & i_cfg_ch_en;
    assign any_elig = |elig;
    assign acc_next = acc_reg + ACC_W'(i_dig_ring_pwr);

    // Round robin = lowest eligible index above last_grant, else wrap to lowest overall.
    always_comb begin
        winner_lo = '0;
        winner_hi = '0;
        found_hi  = 1'b0;
        win_code  = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (elig[j]) begin
                winner_lo = GW'(j);
                if (GW'(j) > last_grant_reg) begin
                    winner_hi = GW'(j);
                    found_hi  = 1'b1;
                end
            end
        end
        winner = (i_cfg_arb_rr && found_hi) ? winner_hi : winner_lo;
        for (int j = 0; j < NUM_CH; j++) begin
            if (winner == GW'(j)) win_code = i_req_ring_tune[j*DAC_WIDTH +: DAC_WIDTH];
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (any_elig) state_next = ST_DRIVE;
            ST_DRIVE:  if (i_afe_ring_tune_rdy) state_next = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
            ST_SETTLE: if (cnt_reg == SETTLE_LAST) state_next = ST_SAMPLE;
            ST_SAMPLE: if (cnt_reg == SAMPLE_LAST) state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= '0;
            last_grant_reg <= GW'(NUM_CH - 1);
            tune_reg       <= '0;
            rsp_tune_reg   <= '0;
            rsp_pwr_reg    <= '0;
            acc_reg        <= '0;
            cnt_reg        <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (any_elig) begin
                        tune_reg       <= win_code;
                        grant_reg      <= winner;
                        last_grant_reg <= winner;
                    end
                    cnt_reg <= '0;
                    acc_reg <= '0;
                end
                ST_SETTLE: cnt_reg <= (cnt_reg == SETTLE_LAST) ? '0 : cnt_reg + 1'b1;
                ST_SAMPLE: begin
                    if (cnt_reg == SAMPLE_LAST) begin
                        cnt_reg      <= '0;
                        acc_reg      <= '0;
                        rsp_tune_reg <= tune_reg;
                        rsp_pwr_reg  <= ADC_WIDTH'(acc_next >> AVG_LOG2);
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                        acc_reg <= acc_next;
                    end
                end
                default: cnt_reg <= '0;
            endcase
        end
    end

    // Reset gates the accept strobe so every output reads 0 while reset is held.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign o_req_rdy[gi] = i_rst_n && (state_reg == ST_IDLE) && any_elig && (winner == GW'(gi));
        assign o_rsp_val[gi] = (state_reg == ST_RESP) && (grant_reg == GW'(gi));
    end

    assign o_rsp_ring_tune     = rsp_tune_reg;
    assign o_rsp_ring_pwr      = rsp_pwr_reg;
    assign o_dig_afe_ring_tune = tune_reg;
    assign o_afe_ring_tune_val = (state_reg == ST_DRIVE);
    assign o_grant_ch          = grant_reg;
    assign o_busy              = (state_reg != ST_IDLE);
    assign o_state_mon         = state_reg;
endmodule

// File: tb/tb_tuner_ctrl_arb_mc.sv
// Directed bench for tuner_ctrl_arb_mc: default build plus a SETTLE_CYCLES=0 build.
module tb_tuner_ctrl_arb_mc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pwr = '0;
    logic        rr = 1'b0;
    logic [2:0]  en = 3'b111;
    logic [2:0]  req_val = '0;
    logic [2:0]  req_val_z = '0;
    logic [23:0] req_tune = '0;
    logic        afe_rdy = 1'b1;
    logic        afe_rdy_z = 1'b1;

    logic [2:0] req_rdy, rsp_val, req_rdy_z, rsp_val_z;
    logic [7:0] rsp_tune, rsp_pwr, afe_tune, rsp_tune_z, rsp_pwr_z, afe_tune_z;
    logic       afe_val, busy, afe_val_z, busy_z;
    logic [1:0] grant, grant_z;
    logic [2:0] state, state_z;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tuner_ctrl_arb_mc dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_dig_ring_pwr(pwr), .i_cfg_arb_rr(rr),
        .i_cfg_ch_en(en), .i_req_val(req_val), .i_req_ring_tune(req_tune),
        .o_req_rdy(req_rdy), .o_rsp_val(rsp_val), .o_rsp_ring_tune(rsp_tune),
        .o_rsp_ring_pwr(rsp_pwr), .o_dig_afe_ring_tune(afe_tune),
        .o_afe_ring_tune_val(afe_val), .i_afe_ring_tune_rdy(afe_rdy),
        .o_grant_ch(grant), .o_busy(busy), .o_state_mon(state)
    );

    tuner_ctrl_arb_mc #(.SETTLE_CYCLES(0)) dut_s0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_dig_ring_pwr(pwr), .i_cfg_arb_rr(rr),
        .i_cfg_ch_en(en), .i_req_val(req_val_z), .i_req_ring_tune(req_tune),
        .o_req_rdy(req_rdy_z), .o_rsp_val(rsp_val_z), .o_rsp_ring_tune(rsp_tune_z),
        .o_rsp_ring_pwr(rsp_pwr_z), .o_dig_afe_ring_tune(afe_tune_z),
        .o_afe_ring_tune_val(afe_val_z), .i_afe_ring_tune_rdy(afe_rdy_z),
        .o_grant_ch(grant_z), .o_busy(busy_z), .o_state_mon(state_z)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for an accept, checks the winner and the gap since the last accept.
    task automatic expect_grant(input string tag, input int exp_ch, input int exp_wait);
        int n;
        logic [2:0] exp_rdy;
        n = 0;
        exp_rdy = 3'b001 << exp_ch;
        #1;
        while (req_rdy == 3'b000 && n < 30) begin
            tick();
            n++;
        end
        check_val(tag, {29'd0, req_rdy}, {29'd0, exp_rdy});
        if (exp_wait >= 0) check_val({tag, "_gap"}, n, exp_wait);
        $display("grant %s: rdy=%b after %0d cycles", tag, req_rdy, n);
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        do_reset();
        check_val("rst_state", state, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_grant", grant, 0);
        check_val("rst_afe_val", afe_val, 0);
        check_val("rst_rsp_pwr", rsp_pwr, 0);

        // Single request on ch1
        req_tune = 24'h005A00;
        req_val  = 3'b010;
        pwr      = 8'h40;
        #1;
        check_val("t1_rdy", req_rdy, 3'b010);
        tick();
        check_val("t1_afe_val", afe_val, 1);
        check_val("t1_afe_tune", afe_tune, 8'h5A);
        check_val("t1_grant", grant, 1);
        req_val = 3'b000;
        tick();
        check_val("t1_settle", state, 2);
        repeat (7) tick();
        check_val("t1_rsp_early", rsp_val, 0);
        check_val("t1_sample", state, 3);
        tick();
        check_val("t1_rsp_val", rsp_val, 3'b010);
        check_val("t1_rsp_pwr", rsp_pwr, 8'h40);
        check_val("t1_rsp_tune", rsp_tune, 8'h5A);
        $display("txn t1: ch1 tune=0x%0h pwr=0x%0h", rsp_tune, rsp_pwr);
        tick();
        check_val("t1_idle", state, 0);
        check_val("t1_rsp_hold", rsp_pwr, 8'h40);
        check_val("t1_afe_keep", afe_tune, 8'h5A);

        // Fixed priority
        req_tune = 24'h332211;
        rr = 1'b0;
        en = 3'b111;
        req_val = 3'b111;
        expect_grant("fix_a", 0, -1);
        expect_grant("fix_b", 0, 10);
        req_val = 3'b110;
        expect_grant("fix_c", 1, 10);
        req_val = 3'b111;
        en = 3'b110;
        expect_grant("fix_mask", 1, 10);
        req_val = 3'b000;
        en = 3'b111;
        repeat (12) tick();

        // Round robin from reset
        do_reset();
        rr = 1'b1;
        req_val = 3'b111;
        expect_grant("rr_0", 0, -1);
        expect_grant("rr_1", 1, 10);
        expect_grant("rr_2", 2, 10);
        expect_grant("rr_3", 0, 10);
        expect_grant("rr_4", 1, 10);
        expect_grant("rr_5", 2, 10);
        en = 3'b101;
        expect_grant("rrm_0", 0, 10);
        expect_grant("rrm_1", 2, 10);
        expect_grant("rrm_2", 0, 10);
        expect_grant("rrm_3", 2, 10);
        req_val = 3'b000;
        en = 3'b111;
        repeat (12) tick();

        // Averaging: 10,11,12,14 -> 47>>2 = 11
        rr = 1'b0;
        req_tune = 24'h000077;
        req_val = 3'b001;
        pwr = 8'd200;
        #1;
        check_val("avg_rdy", req_rdy, 3'b001);
        tick();
        req_val = 3'b000;
        repeat (5) tick();
        pwr = 8'd10; tick();
        pwr = 8'd11; tick();
        pwr = 8'd12; tick();
        pwr = 8'd14; tick();
        pwr = 8'd0;
        check_val("avg_rsp_val", rsp_val, 3'b001);
        check_val("avg_pwr", rsp_pwr, 8'd11);
        check_val("avg_tune", rsp_tune, 8'h77);
        $display("txn avg: ch0 pwr=%0d", rsp_pwr);
        tick();
        pwr = 8'hFF;
        req_val = 3'b001;
        #1;
        check_val("max_rdy", req_rdy, 3'b001);
        tick();
        req_val = 3'b000;
        repeat (9) tick();
        check_val("max_rsp_val", rsp_val, 3'b001);
        check_val("max_pwr", rsp_pwr, 8'hFF);
        $display("txn max: ch0 pwr=0x%0h", rsp_pwr);
        tick();

        // SETTLE_CYCLES=0 build with AFE backpressure
        req_tune = 24'h330000;
        pwr = 8'h20;
        afe_rdy_z = 1'b0;
        req_val_z = 3'b100;
        #1;
        check_val("bp_rdy", req_rdy_z, 3'b100);
        tick();
        req_val_z = 3'b000;
        check_val("bp_val1", afe_val_z, 1);
        check_val("bp_code1", afe_tune_z, 8'h33);
        tick();
        check_val("bp_val2", afe_val_z, 1);
        tick();
        check_val("bp_val3", afe_val_z, 1);
        check_val("bp_code3", afe_tune_z, 8'h33);
        tick();
        afe_rdy_z = 1'b1;
        #1;
        check_val("bp_drive4", state_z, 1);
        tick();
        check_val("bp_sample", state_z, 3);
        check_val("bp_val_low", afe_val_z, 0);
        repeat (3) tick();
        check_val("bp_rsp_early", rsp_val_z, 0);
        tick();
        check_val("bp_rsp_val", rsp_val_z, 3'b100);
        check_val("bp_rsp_pwr", rsp_pwr_z, 8'h20);
        check_val("bp_rsp_tune", rsp_tune_z, 8'h33);
        $display("txn bp: ch2 tune=0x%0h pwr=0x%0h", rsp_tune_z, rsp_pwr_z);
        tick();
        check_val("bp_idle", state_z, 0);

        // Async reset in SAMPLE; last_grant is 0 here so rr picks ch1 first
        rr = 1'b1;
        req_tune = 24'h005A00;
        pwr = 8'h30;
        req_val = 3'b010;
        expect_grant("pre_rst", 1, -1);
        req_val = 3'b000;
        repeat (5) tick();
        check_val("pre_rst_sample", state, 3);
        #2;
        req_val = 3'b010;
        rst_n = 1'b0;
        #1;
        check_val("ar_state", state, 0);
        check_val("ar_busy", busy, 0);
        check_val("ar_afe_val", afe_val, 0);
        check_val("ar_afe_tune", afe_tune, 0);
        check_val("ar_rsp_pwr", rsp_pwr, 0);
        check_val("ar_rsp_tune", rsp_tune, 0);
        check_val("ar_req_rdy", req_rdy, 0);
        req_val = 3'b000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("ar_rsp_held", rsp_val, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_val("ar_no_rsp", rsp_val, 0);
        end
        req_val = 3'b111;
        expect_grant("post_rst", 0, -1);
        req_val = 3'b000;
        repeat (12) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
